load_store_unit: RTL and testbench
==================================

Name: load_store_unit

Overview:
- Memory-side writer for the register file in the multicycle MIPS core.
- Accepts one load/store request per instruction and runs it as an Avalon-MM master.
  - Stores: generates lane-replicated writedata and byteenable.
  - Loads: extracts, sign/zero-extends or merges (LWL/LWR) the returned word into a 32-bit writeback value with a one-cycle register-write strobe.
- Sits between the ALU effective-address output and the data bus. Its load_data/load_valid feed the register file write port during WRITE_BACK.

Parameters:
- ADDR_WIDTH, 32, width of effective address and bus address.

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-high.
- start  in  1  request strobe, sampled only in IDLE.
- opcode  in  6  instr[31:26] of the memory instruction.
- eff_addr  in  ADDR_WIDTH  byte address (base + offset).
- rt_data  in  32  store source / current rt value for LWL/LWR merge.
- address  out  ADDR_WIDTH  word-aligned bus address ({eff_addr[31:2],2'b00}).
- read  out  1  Avalon read.
- write  out  1  Avalon write.
- writedata  out  32  Avalon write data.
- byteenable  out  4  lane enables; lane n = bits 8n+7:8n = byte offset n (little-endian).
- readdata  in  32  Avalon read data.
- waitrequest  in  1  Avalon stall.
- busy  out  1  high in REQ and DONE.
- done  out  1  one-cycle completion pulse.
- load_valid  out  1  register-write strobe; high with done for loads only.
- load_data  out  32  writeback value for rt.
- addr_error  out  1  misalignment flag; pulses with done, no bus cycle issued.

Behaviour:
- Reset: state IDLE. All outputs low or 0: read, write, busy, done, load_valid, addr_error, address, writedata, byteenable, load_data.
- Opcodes: LB 100000, LH 100001, LWL 100010, LW 100011, LBU 100100, LHU 100101, LWR 100110, SB 101000, SH 101001, SW 101011.
- Any other opcode with start is ignored: stay IDLE, no done.
- FSM states: IDLE, REQ, DONE.
- IDLE + start + valid opcode:
  - Latch opcode, eff_addr, rt_data.
  - Aligned request -> REQ.
  - Misaligned request (LW/SW with addr[1:0]!=0; LH/LHU/SH with addr[0]!=0) -> DONE with addr_error=1.
- REQ:
  - Assert read (loads) or write (stores). Hold address, byteenable, writedata constant.
  - waitrequest=1: stay in REQ.
  - waitrequest=0: transfer completes this cycle. Capture readdata into the extract/merge path and go to DONE.
  - Read and write are never asserted together.
- DONE:
  - done=1 for exactly one cycle; load_valid=1 iff load and no addr_error; then IDLE.
  - load_data is valid with load_valid and holds until the next load completes.
- Minimum latency: start at cycle 0 -> bus request in cycle 1 -> done in cycle 2. Each waitrequest cycle adds one.
- start while busy: ignored, not queued.
- Byteenable, k = eff_addr[1:0]:
  - LB/LBU/SB: 1<<k.
  - LH/LHU/SH: k=0 -> 0011; k=2 -> 1100.
  - LW/SW: 1111.
  - LWL: lanes 0..k.
  - LWR: lanes k..3.
- Store data:
  - SB: {4{rt[7:0]}}.
  - SH: {2{rt[15:0]}}.
  - SW: rt.
- Load data, w = readdata:
  - LB/LBU: byte k, sign/zero-extended.
  - LH/LHU: halfword k/2, sign/zero-extended.
  - LW: w.
  - LWL: (w << 8*(3-k)) | (rt & low (3-k) bytes mask).
  - LWR: (w >> 8*k) | (rt & high k bytes mask).
- Reset asserted in REQ or DONE: next edge returns to IDLE with all outputs cleared. The pending transfer is abandoned and no done is issued.

Decomposition:
- mips_pkg holds:
  - opcode_t enum containing the ten memory opcodes; shared with decode and the register file.
  - lsu_state_t {IDLE, REQ, DONE}.
- Sub-module lsu_lane_logic: purely combinational. Maps (opcode, k, rt_data, readdata) to byteenable, writedata and load_data. It is reused by the top-level FSM, which owns all state and the Avalon handshake.

Test Plan:
- LW at 0x1000, waitrequest low, readdata 0xDEADBEEF -> read in cycle 1, address 0x1000, byteenable 1111; cycle 2 done=1, load_valid=1, load_data 0xDEADBEEF.
- LB at 0x1003, readdata 0x80FF1234 -> byteenable 1000, load_data 0xFFFFFF80. LBU at the same address -> 0x00000080.
- SH at 0x2002, rt 0x0000ABCD, waitrequest high 3 cycles -> write held 4 cycles with address 0x2000, writedata 0xABCDABCD, byteenable 1100; done 1 cycle after acceptance; load_valid=0.
- LWL k=1, readdata 0x44332211, rt 0xAABBCCDD -> byteenable 0011, load_data 0x2211CCDD. LWR k=1 with the same inputs -> byteenable 1110, load_data 0xAA443322.
- LW at 0x1002 -> no read asserted, done and addr_error both pulse in cycle 1, load_valid=0.
- Reset during REQ with waitrequest high -> next cycle read=0, busy=0, no done. Second start during busy -> ignored.

Source files
------------

// File: rtl/mips_pkg.sv
// Shared MIPS definitions: memory opcodes, load/store FSM state encoding, and opcode classification helpers.
package mips_pkg;

    typedef enum logic [5:0] {
        OP_LB  = 6'b100000,
        OP_LH  = 6'b100001,
        OP_LWL = 6'b100010,
        OP_LW  = 6'b100011,
        OP_LBU = 6'b100100,
        OP_LHU = 6'b100101,
        OP_LWR = 6'b100110,
        OP_SB  = 6'b101000,
        OP_SH  = 6'b101001,
        OP_SW  = 6'b101011
    } opcode_t;

    typedef logic [1:0] lsu_state_t;
    localparam lsu_state_t IDLE = 2'd0;
    localparam lsu_state_t REQ  = 2'd1;
    localparam lsu_state_t DONE = 2'd2;

    function automatic logic is_mem_op(input logic [5:0] op);
        case (op)
            OP_LB, OP_LH, OP_LWL, OP_LW, OP_LBU, OP_LHU, OP_LWR,
            OP_SB, OP_SH, OP_SW: is_mem_op = 1'b1;
            default:             is_mem_op = 1'b0;
        endcase
    endfunction

    // Loads live in 100xxx, stores in 101xxx.
    function automatic logic is_load_op(input logic [5:0] op);
        is_load_op = ~op[3];
    endfunction

    function automatic logic is_misaligned(input logic [5:0] op, input logic [1:0] k);
        case (op)
            OP_LW, OP_SW:          is_misaligned = (k != 2'b00);
            OP_LH, OP_LHU, OP_SH:  is_misaligned = k[0];
            default:               is_misaligned = 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/lsu_lane_logic.sv
// Combinational byte-lane steering: byteenable and replicated store data, plus
// extract/extend/merge of the returned word into the rt writeback value.
module lsu_lane_logic
    import mips_pkg::*;
(
    input  logic [5:0]  opcode,
    input  logic [1:0]  k,
    input  logic [31:0] rt_data,
    input  logic [31:0] readdata,
    output logic [3:0]  byteenable,
    output logic [31:0] writedata,
    output logic [31:0] load_data
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;
    logic [31:0] lwl_mask;
    logic [31:0] lwr_mask;
    logic [3:0]  lwl_be;
    logic [3:0]  lwr_be;

    // LWL keeps the low (3-k) bytes of rt; LWR keeps the high k bytes.
    always_comb begin
        lwl_mask = 32'h0;
        lwr_mask = 32'h0;
        lwl_be   = 4'b1111;
        lwr_be   = 4'b1111;
        case (k)
            2'd0: begin lwl_mask = 32'h00FF_FFFF; lwr_mask = 32'h0000_0000; lwl_be = 4'b0001; lwr_be = 4'b1111; end
            2'd1: begin lwl_mask = 32'h0000_FFFF; lwr_mask = 32'hFF00_0000; lwl_be = 4'b0011; lwr_be = 4'b1110; end
            2'd2: begin lwl_mask = 32'h0000_00FF; lwr_mask = 32'hFFFF_0000; lwl_be = 4'b0111; lwr_be = 4'b1100; end
            default: begin lwl_mask = 32'h0000_0000; lwr_mask = 32'hFFFF_FF00; lwl_be = 4'b1111; lwr_be = 4'b1000; end
        endcase
    end

    always_comb begin
        byte_sel = 8'h0;
        case (k)
            2'd0:    byte_sel = readdata[7:0];
            2'd1:    byte_sel = readdata[15:8];
            2'd2:    byte_sel = readdata[23:16];
            default: byte_sel = readdata[31:24];
        endcase
        half_sel = k[1] ? readdata[31:16] : readdata[15:0];
    end

    always_comb begin
        byteenable = 4'b0000;
        writedata  = 32'h0;
        load_data  = 32'h0;
        case (opcode)
            OP_LB:  begin byteenable = 4'b0001 << k; load_data = {{24{byte_sel[7]}}, byte_sel}; end
            OP_LBU: begin byteenable = 4'b0001 << k; load_data = {24'h0, byte_sel}; end
            OP_LH:  begin byteenable = k[1] ? 4'b1100 : 4'b0011; load_data = {{16{half_sel[15]}}, half_sel}; end
            OP_LHU: begin byteenable = k[1] ? 4'b1100 : 4'b0011; load_data = {16'h0, half_sel}; end
            OP_LW:  begin byteenable = 4'b1111; load_data = readdata; end
            OP_LWL: begin byteenable = lwl_be; load_data = (readdata << {~k, 3'b000}) | (rt_data & lwl_mask); end
            OP_LWR: begin byteenable = lwr_be; load_data = (readdata >> {k, 3'b000}) | (rt_data & lwr_mask); end
            OP_SB:  begin byteenable = 4'b0001 << k; writedata = {4{rt_data[7:0]}}; end
            OP_SH:  begin byteenable = k[1] ? 4'b1100 : 4'b0011; writedata = {2{rt_data[15:0]}}; end
            OP_SW:  begin byteenable = 4'b1111; writedata = rt_data; end
            default: ;
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// Load/store unit: runs one memory instruction as an Avalon-MM master and
// produces a one-cycle register-file write strobe for loads.
module load_store_unit
    import mips_pkg::*;
#(
    parameter int ADDR_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic [5:0]            opcode,
    input  logic [ADDR_WIDTH-1:0] eff_addr,
    input  logic [31:0]           rt_data,
    output logic [ADDR_WIDTH-1:0] address,
    output logic                  read,
    output logic                  write,
    output logic [31:0]           writedata,
    output logic [3:0]            byteenable,
    input  logic [31:0]           readdata,
    input  logic                  waitrequest,
    output logic                  busy,
    output logic                  done,
    output logic                  load_valid,
    output logic [31:0]           load_data,
    output logic                  addr_error
);

    lsu_state_t            state;
    logic [5:0]            op_q;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [31:0]           rt_q;
    logic                  err_q;
    logic [31:0]           load_data_q;

    logic [3:0]  lane_be;
    logic [31:0] lane_wdata;
    logic [31:0] lane_ldata;
    logic        in_req;
    logic        op_is_load;

    lsu_lane_logic u_lane (
        .opcode     (op_q),
        .k          (addr_q[1:0]),
        .rt_data    (rt_q),
        .readdata   (readdata),
        .byteenable (lane_be),
        .writedata  (lane_wdata),
        .load_data  (lane_ldata)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            op_q        <= 6'h0;
            addr_q      <= '0;
            rt_q        <= 32'h0;
            err_q       <= 1'b0;
            load_data_q <= 32'h0;
        end else begin
            case (state)
                IDLE: begin
                    if (start && is_mem_op(opcode)) begin
                        op_q   <= opcode;
                        addr_q <= eff_addr;
                        rt_q   <= rt_data;
                        err_q  <= is_misaligned(opcode, eff_addr[1:0]);
                        state  <= is_misaligned(opcode, eff_addr[1:0]) ? DONE : REQ;
                    end
                end
                REQ: begin
                    if (!waitrequest) begin
                        // readdata is only valid in the accepting cycle, so merge it now
                        if (op_is_load) load_data_q <= lane_ldata;
                        state <= DONE;
                    end
                end
                DONE: begin
                    err_q <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign in_req     = (state == REQ);
    assign op_is_load = is_load_op(op_q);

    // Bus outputs are forced to zero outside REQ so idle cycles look clean on the bus.
    assign address    = in_req ? {addr_q[ADDR_WIDTH-1:2], 2'b00} : '0;
    assign read       = in_req && op_is_load;
    assign write      = in_req && !op_is_load;
    assign byteenable = in_req ? lane_be : 4'b0000;
    assign writedata  = (in_req && !op_is_load) ? lane_wdata : 32'h0;

    assign busy       = (state == REQ) || (state == DONE);
    assign done       = (state == DONE);
    assign addr_error = (state == DONE) && err_q;
    assign load_valid = (state == DONE) && op_is_load && !err_q;
    assign load_data  = load_data_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Scoreboard bench for load_store_unit: stimulus pushes expected bus cycles and
// completions; a negedge monitor pops and compares them as the DUT presents them.
module tb_load_store_unit;
    import mips_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [5:0]  opcode;
    logic [31:0] eff_addr;
    logic [31:0] rt_data;
    logic [31:0] address;
    logic        read, write;
    logic [31:0] writedata;
    logic [3:0]  byteenable;
    logic [31:0] readdata;
    logic        waitrequest;
    logic        busy, done, load_valid, addr_error;
    logic [31:0] load_data;

    int vectors = 0;
    int miscompares = 0;

    typedef struct {
        logic [31:0] addr;
        logic [3:0]  be;
        logic [31:0] wd;
        logic        is_rd;
    } bus_exp_t;

    typedef struct {
        logic        lv;
        logic [31:0] ld;
        logic        ae;
    } done_exp_t;

    bus_exp_t  bus_q[$];
    done_exp_t done_q[$];

    load_store_unit #(.ADDR_WIDTH(32)) dut (
        .clk(clk), .reset(reset), .start(start), .opcode(opcode),
        .eff_addr(eff_addr), .rt_data(rt_data), .address(address),
        .read(read), .write(write), .writedata(writedata), .byteenable(byteenable),
        .readdata(readdata), .waitrequest(waitrequest), .busy(busy), .done(done),
        .load_valid(load_valid), .load_data(load_data), .addr_error(addr_error)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: every bus cycle and every completion is matched against the scoreboard.
    always @(negedge clk) begin
        if (!reset) begin
            if (read && write) check("rd_wr_overlap", 32'd1, 32'd0);
            if (read || write) begin
                if (bus_q.size() == 0) begin
                    check("unexpected_bus", 32'd1, 32'd0);
                end else begin
                    check("bus_addr", address, bus_q[0].addr);
                    check("bus_be", {28'h0, byteenable}, {28'h0, bus_q[0].be});
                    check("bus_dir", {30'h0, read, write}, {30'h0, bus_q[0].is_rd, !bus_q[0].is_rd});
                    if (!bus_q[0].is_rd) check("bus_wdata", writedata, bus_q[0].wd);
                    if (!waitrequest) void'(bus_q.pop_front());
                end
            end
            if (done) begin
                if (done_q.size() == 0) begin
                    check("unexpected_done", 32'd1, 32'd0);
                end else begin
                    check("load_valid", {31'h0, load_valid}, {31'h0, done_q[0].lv});
                    check("addr_error", {31'h0, addr_error}, {31'h0, done_q[0].ae});
                    if (done_q[0].lv) check("load_data", load_data, done_q[0].ld);
                    void'(done_q.pop_front());
                end
            end
        end
    end

    // Issue one request; waits = stalled REQ cycles; poke = fire a second start while busy.
    task automatic run(input logic [5:0] op, input logic [31:0] addr, input logic [31:0] rt,
                       input logic [31:0] rd, input int waits, input logic poke,
                       input logic [31:0] exp_baddr, input logic [3:0] exp_be,
                       input logic [31:0] exp_wd, input logic exp_err,
                       input logic exp_lv, input logic [31:0] exp_ld);
        bus_exp_t  b;
        done_exp_t d;
        bit got = 0;
        int lat = exp_err ? 1 : 2 + waits;
        if (!exp_err) begin
            b.addr = exp_baddr; b.be = exp_be; b.wd = exp_wd; b.is_rd = ~op[3];
            bus_q.push_back(b);
        end
        d.lv = exp_lv; d.ld = exp_ld; d.ae = exp_err;
        done_q.push_back(d);
        @(posedge clk); #1;
        start = 1'b1; opcode = op; eff_addr = addr; rt_data = rt; readdata = rd;
        waitrequest = (waits > 0);
        for (int c = 1; c <= 30 && !got; c++) begin
            @(posedge clk); #1;
            start = poke && (c == 1);
            if (poke && c == 1) begin opcode = OP_LW; eff_addr = 32'h0000_7000; end
            waitrequest = (c <= waits);
            @(negedge clk);
            if (done) begin
                got = 1;
                check("latency", c, lat);
            end
        end
        if (!got) check("done_timeout", 32'd0, 32'd1);
        @(posedge clk); #1;
        start = 1'b0; waitrequest = 1'b0;
    endtask

    initial begin
        reset = 1'b1; start = 1'b0; opcode = 6'h0; eff_addr = 32'h0;
        rt_data = 32'h0; readdata = 32'h0; waitrequest = 1'b0;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        check("rst_bus", {read, write, byteenable, 26'h0}, 32'h0);
        check("rst_addr", address, 32'h0);
        check("rst_wdata", writedata, 32'h0);
        check("rst_status", {28'h0, busy, done, load_valid, addr_error}, 32'h0);
        check("rst_load_data", load_data, 32'h0);

        //  op      addr          rt            readdata      w  poke  bus addr      be       wdata         err  lv  load_data
        run(OP_LW,  32'h0000_1000, 32'h0,        32'hDEAD_BEEF, 0, 0, 32'h0000_1000, 4'b1111, 32'h0,         0, 1, 32'hDEAD_BEEF);
        run(OP_LB,  32'h0000_1003, 32'h0,        32'h80FF_1234, 0, 0, 32'h0000_1000, 4'b1000, 32'h0,         0, 1, 32'hFFFF_FF80);
        run(OP_LBU, 32'h0000_1003, 32'h0,        32'h80FF_1234, 0, 0, 32'h0000_1000, 4'b1000, 32'h0,         0, 1, 32'h0000_0080);
        run(OP_SH,  32'h0000_2002, 32'h0000_ABCD, 32'h0,        3, 0, 32'h0000_2000, 4'b1100, 32'hABCD_ABCD, 0, 0, 32'h0);
        check("load_data_hold", load_data, 32'h0000_0080);
        run(OP_LWL, 32'h0000_3001, 32'hAABB_CCDD, 32'h4433_2211, 0, 0, 32'h0000_3000, 4'b0011, 32'h0,       0, 1, 32'h2211_CCDD);
        run(OP_LWR, 32'h0000_3001, 32'hAABB_CCDD, 32'h4433_2211, 0, 0, 32'h0000_3000, 4'b1110, 32'h0,       0, 1, 32'hAA44_3322);
        run(OP_LW,  32'h0000_1002, 32'h0,        32'h1111_1111, 0, 0, 32'h0,         4'b0000, 32'h0,         1, 0, 32'h0);
        run(OP_LH,  32'h0000_4002, 32'h0,        32'h8765_4321, 0, 0, 32'h0000_4000, 4'b1100, 32'h0,         0, 1, 32'hFFFF_8765);
        run(OP_LHU, 32'h0000_4000, 32'h0,        32'h8765_4321, 1, 0, 32'h0000_4000, 4'b0011, 32'h0,         0, 1, 32'h0000_4321);
        run(OP_SB,  32'h0000_5002, 32'h1234_56AB, 32'h0,        0, 0, 32'h0000_5000, 4'b0100, 32'hABAB_ABAB, 0, 0, 32'h0);
        run(OP_SW,  32'h0000_6000, 32'hCAFE_F00D, 32'h0,        2, 1, 32'h0000_6000, 4'b1111, 32'hCAFE_F00D, 0, 0, 32'h0);
        run(OP_SH,  32'h0000_2001, 32'h0000_1234, 32'h0,        0, 0, 32'h0,         4'b0000, 32'h0,         1, 0, 32'h0);
        run(OP_LWL, 32'h0000_3003, 32'hAABB_CCDD, 32'h4433_2211, 0, 0, 32'h0000_3000, 4'b1111, 32'h0,       0, 1, 32'h4433_2211);
        run(OP_LWR, 32'h0000_3000, 32'hAABB_CCDD, 32'h4433_2211, 0, 0, 32'h0000_3000, 4'b1111, 32'h0,       0, 1, 32'h4433_2211);

        // Invalid opcode is ignored.
        @(posedge clk); #1;
        start = 1'b1; opcode = 6'b000000; eff_addr = 32'h0000_1000;
        @(posedge clk); #1;
        start = 1'b0;
        @(negedge clk);
        check("bad_op_busy", {31'h0, busy}, 32'h0);

        // Reset while stalled in REQ abandons the transfer.
        begin
            bus_exp_t b;
            b.addr = 32'h0000_8000; b.be = 4'b1111; b.wd = 32'h0; b.is_rd = 1'b1;
            bus_q.push_back(b);
        end
        @(posedge clk); #1;
        start = 1'b1; opcode = OP_LW; eff_addr = 32'h0000_8000; waitrequest = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        @(negedge clk);
        check("req_read", {31'h0, read}, 32'h1);
        @(posedge clk); #1;
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        bus_q.delete();
        @(negedge clk);
        check("post_rst_read", {31'h0, read}, 32'h0);
        check("post_rst_busy", {31'h0, busy}, 32'h0);
        check("post_rst_done", {31'h0, done}, 32'h0);
        waitrequest = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("post_rst_idle", {30'h0, busy, done}, 32'h0);
        check("bus_q_empty", bus_q.size(), 32'd0);
        check("done_q_empty", done_q.size(), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
